// File: rtl/load_ctrl.sv
// rtl/load_ctrl.sv - debounced pushbutton to single load strobe, then LCD refresh handshake with timeout
module load_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       load_pulse,
  output logic       lcd_req,
  input  logic       lcd_done,
  output logic       busy,
  output logic       err,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, RELEASE} stateT;

  localparam logic [CNT_W-1:0] DebLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  stateT            state;
  stateT            nextState;
  logic             syncMeta;
  logic             btnS;
  logic             deb;
  logic             debPrev;
  logic [CNT_W-1:0] debCnt;
  logic [CNT_W-1:0] toCnt;
  logic             pressEvt;
  logic             timeout;

  // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncMeta <= 1'b0;
      btnS     <= 1'b0;
      deb      <= 1'b0;
      debPrev  <= 1'b0;
      debCnt   <= '0;
    end else begin
      syncMeta <= btn_raw;
      btnS     <= syncMeta;
      debPrev  <= deb;
      if (btnS == deb) begin
        debCnt <= '0;
      end else if (debCnt == DebLast) begin
        deb    <= btnS;
        debCnt <= '0;
      end else begin
        debCnt <= debCnt + CntOne;
      end
    end
  end

  assign pressEvt = deb & ~debPrev;
  assign timeout  = (toCnt == TimeoutLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      toCnt       <= '0;
      err         <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state <= nextState;
      if (state == LOAD) begin
        toCnt <= '0;
        err   <= 1'b0;
        if (press_count != 8'hFF) begin
          press_count <= press_count + 8'd1;
        end
      end else if (state == REQ) begin
        toCnt <= toCnt + CntOne;
        // A completion arriving on the expiry cycle still counts as success.
        if (timeout && !lcd_done) begin
          err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    nextState  = state;
    load_pulse = 1'b0;
    lcd_req    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pressEvt) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        load_pulse = 1'b1;
        nextState  = REQ;
      end
      REQ: begin
        lcd_req = 1'b1;
        if (lcd_done || timeout) begin
          nextState = RELEASE;
        end
      end
      RELEASE: begin
        if (!deb) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_ctrl.sv
// tb/tb_load_ctrl.sv - scoreboard bench for load_ctrl
module tb_load_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       doneResp = 1'b0;
  logic       doneStray = 1'b0;
  logic       lcd_done;
  logic       load_pulse;
  logic       lcd_req;
  logic       busy;
  logic       err;
  logic [7:0] press_count;

  assign lcd_done = doneResp | doneStray;

  load_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .load_pulse (load_pulse),
    .lcd_req    (lcd_req),
    .lcd_done   (lcd_done),
    .busy       (busy),
    .err        (err),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {int atCyc; int count;} loadExpT;
  typedef struct {int len; int errVal;} reqExpT;
  loadExpT loadQ[$];
  reqExpT  reqQ[$];

  int doneDelay  = 3;
  int modelCount = 0;

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT strobes a load or ends a request.
  bit      postPending = 0;
  int      postCount = 0;
  int      reqLen = 0;
  logic    reqPrev = 1'b0;
  loadExpT curLoad;
  reqExpT  curReq;

  always @(negedge clk) begin
    if (!rst) begin
      postPending = 0;
      reqLen      = 0;
      reqPrev     = 1'b0;
    end else begin
      if (postPending) begin
        check("load_width", int'(load_pulse), 0);
        check("press_count", int'(press_count), postCount);
        check("err_after_load", int'(err), 0);
        postPending = 0;
      end
      if (load_pulse) begin
        if (loadQ.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          curLoad = loadQ.pop_front();
          check("load_cycle", cyc, curLoad.atCyc);
          postPending = 1;
          postCount   = curLoad.count;
        end
      end
      if (lcd_req) begin
        reqLen++;
      end else if (reqPrev) begin
        if (reqQ.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          curReq = reqQ.pop_front();
          check("req_len", reqLen, curReq.len);
          check("req_err", int'(err), curReq.errVal);
        end
        reqLen = 0;
      end
      reqPrev = lcd_req;
    end
  end

  // LCD model: pulses done doneDelay cycles after lcd_req rises; negative means never.
  bit respSeen = 0;
  always begin
    @(negedge clk);
    if (rst && lcd_req && !respSeen) begin
      respSeen = 1;
      if (doneDelay >= 0) begin
        repeat (doneDelay) @(posedge clk);
        #1 doneResp = 1'b1;
        @(posedge clk);
        #1 doneResp = 1'b0;
      end
    end else if (!lcd_req) begin
      respSeen = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectPress(input int edgeCyc, input int len, input int errVal);
    if (modelCount < 255) modelCount++;
    loadQ.push_back('{atCyc: edgeCyc + DEB + 3, count: modelCount});
    reqQ.push_back('{len: len, errVal: errVal});
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 300 && busy; i++) step(1);
    check(name, int'(busy), 0);
  endtask

  task automatic pressRelease(input int hold, input int len, input int errVal, input int dly);
    doneDelay = dly;
    btn_raw   = 1'b1;
    expectPress(cyc, len, errVal);
    step(hold);
    btn_raw = 1'b0;
    waitIdle("idle_after_press");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  int edgeCyc;

  initial begin
    #1 rst = 1'b0;
    #1;
    check("rst_load_pulse", int'(load_pulse), 0);
    check("rst_lcd_req", int'(lcd_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_press_count", int'(press_count), 0);
    step(3);
    rst = 1'b1;
    step(2);

    // Clean press, done 3 cycles after request.
    pressRelease(20, 4, 0, 3);

    // Bounce: toggle every 2 cycles for 12 cycles, then hold.
    doneDelay = 3;
    for (int k = 0; k < 6; k++) begin
      btn_raw = (k % 2 == 0);
      step(2);
    end
    btn_raw = 1'b1;
    expectPress(cyc, 4, 0);
    step(20);
    btn_raw = 1'b0;
    waitIdle("idle_after_bounce");

    // Timeout, then next press clears err.
    pressRelease(20, TO, 1, -1);
    check("err_sticky", int'(err), 1);
    step(3);
    check("err_still_sticky", int'(err), 1);
    pressRelease(20, 4, 0, 3);

    // Done on the last REQ cycle wins over timeout.
    pressRelease(20, TO, 0, 15);
    check("collision_err", int'(err), 0);

    // Stray done while idle.
    doneStray = 1'b1;
    step(1);
    doneStray = 1'b0;
    check("stray_busy", int'(busy), 0);
    step(3);
    check("stray_busy_later", int'(busy), 0);
    check("stray_lcd_req", int'(lcd_req), 0);

    // Second debounced press during REQ is dropped.
    doneDelay = -1;
    btn_raw   = 1'b1;
    expectPress(cyc, TO, 1);
    step(9);
    btn_raw = 1'b0;
    step(6);
    btn_raw = 1'b1;
    step(11);
    btn_raw = 1'b0;
    waitIdle("idle_after_drop");
    check("drop_count", int'(press_count), modelCount);

    // Saturation.
    for (int i = 0; i < 300; i++) pressRelease(10, 4, 0, 3);
    check("sat_count", int'(press_count), 255);

    // Reset mid-REQ with the button held through reset release.
    doneDelay = -1;
    btn_raw   = 1'b1;
    loadQ.push_back('{atCyc: cyc + DEB + 3, count: 255});
    step(10);
    check("pre_rst_lcd_req", int'(lcd_req), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_load_pulse", int'(load_pulse), 0);
    check("midrst_lcd_req", int'(lcd_req), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_press_count", int'(press_count), 0);
    step(2);
    doneDelay  = 3;
    modelCount = 0;
    rst        = 1'b1;
    edgeCyc    = cyc;
    check("post_rst_busy", int'(busy), 0);
    expectPress(edgeCyc, 4, 0);
    step(20);
    btn_raw = 1'b0;
    waitIdle("idle_after_held_reset");

    step(5);
    check("load_queue_empty", loadQ.size(), 0);
    check("req_queue_empty", reqQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/load_ctrl.md
Name: load_ctrl

Overview:
- Controller that sequences the 5-bit state load register from a raw front-panel pushbutton.
- Synchronises and debounces the button, then issues exactly one single-cycle load pulse per accepted press.
- After each load, requests an LCD refresh and waits for completion with a timeout.
- Sits between the board button/switches, the load register and the LCD driver.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before the debounced level changes (5 ms at 50 MHz); minimum 2
TIMEOUT_CYCLES, 1000000, max cycles in REQ waiting for lcd_done before abort; minimum 2
CNT_W, 20, width of the internal debounce and timeout counters; must hold max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_raw  input  1  raw pushbutton, asynchronous and bouncy, 1 = pressed
load_pulse  output  1  one-cycle load strobe to the state load register
lcd_req  output  1  LCD refresh request, level
lcd_done  input  1  LCD driver completion, single-cycle pulse
busy  output  1  high in any state other than IDLE
err  output  1  sticky timeout flag
press_count  output  8  number of accepted presses, saturating

Behaviour:
- Reset: one clock; reset asynchronous, active-low (rst=0). While rst=0:
  - FSM forced to IDLE.
  - Synchroniser flops, debounced level, and all counters cleared to 0.
  - load_pulse=0, lcd_req=0, busy=0, err=0, press_count=0.
  - Reset mid-operation aborts everything immediately; no pending load or request survives.
- Synchroniser: btn_raw passes through 2 flops giving btn_s.
- Debouncer:
  - Counter increments each cycle btn_s != deb; clears whenever btn_s == deb.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still != deb, deb <= btn_s and the counter clears.
  - Result: a press is recognised DEBOUNCE_CYCLES+2 cycles after a clean btn_raw edge.
- press_evt: one-cycle pulse on deb 0->1.
  - A button held through reset release is recognised as a press after debounce.
- FSM states: IDLE, LOAD, REQ, RELEASE.
  - IDLE: on press_evt -> LOAD. lcd_done ignored.
  - LOAD: load_pulse=1 for exactly this one cycle; press_count increments (saturates at 255); err cleared; -> REQ unconditionally.
  - REQ:
    - lcd_req=1; timeout counter increments each cycle, starting at 0 on entry.
    - lcd_done=1 -> RELEASE, lcd_req drops the next cycle.
    - Counter reaches TIMEOUT_CYCLES-1 without lcd_done -> err=1, -> RELEASE.
    - lcd_done in the same cycle as timeout expiry: done wins, err stays 0.
  - RELEASE: wait until deb=0 -> IDLE. If deb is already 0 on entry, go to IDLE next cycle.
- Press handling:
  - press_evt outside IDLE is discarded: no queueing, no count.
  - A new press requires a debounced release first.
- Output timing:
  - All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
  - busy = (state != IDLE).
- Load latency: load_pulse rises exactly 1 cycle after press_evt.
- Whole-cycle bound: one press produces at most one load_pulse, regardless of bounce pattern.

Test Plan:
- Reset values (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16): assert rst=0 mid-REQ -> lcd_req, busy, load_pulse, err, press_count all 0 immediately, before the next clk edge; after release, state is IDLE.
- Clean press: btn_raw 0->1 held 20 cycles, lcd_done pulsed 3 cycles after lcd_req rises -> load_pulse high exactly 1 cycle, 7 cycles after the edge; lcd_req high 4 cycles; press_count=1; err=0.
- Bounce rejection: btn_raw toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one load_pulse; press_count=1; glitches shorter than 4 cycles never change deb.
- Timeout: press, lcd_done never asserted -> lcd_req high 16 cycles, then err=1; next accepted press clears err in its LOAD cycle.
- Done/timeout collision: lcd_done asserted on cycle 16 of REQ -> err stays 0. Stray lcd_done in IDLE -> no state change.
- Saturation and drop: 300 clean press/release pairs -> press_count=255; a second debounced press while still in REQ (short btn release then press) -> ignored, single load_pulse.
